inst_fetch_unit: RTL

Instruction-side responder for the CPU core. It accepts a fetch request (PC) from the CPU and returns the 32-bit ARM instruction word at that address, read from a word-addressed instruction memory with variable latency through a req/ack handshake. A single-entry sequential prefetch buffer holds PC+4 so that straight-line code hits with 1-cycle latency. Branch or flush traffic invalidates the buffer.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/prefetch_buf.sv | 41 ++++
 rtl/inst_fetch_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'hE1A00000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEMAND = 2'd1,
        PREF   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/prefetch_buf.sv
// Single-entry sequential prefetch buffer: one tagged instruction word.
module prefetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_tag,
    input  logic [INST_W-1:0] i_load_data,
    input  logic              i_consume,
    input  logic              i_invalidate,
    input  logic [ADDR_W-1:0] i_lookup_tag,
    output logic              o_hit_c,
    output logic [INST_W-1:0] o_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_tag;
    logic [INST_W-1:0] r_data;

    // Clearing wins over a same-cycle load so a flushed fill never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_invalidate || i_consume) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_tag   <= i_load_tag;
            r_data  <= i_load_data;
        end
    end

    assign o_hit_c = r_valid && (r_tag == i_lookup_tag);
    assign o_data  = r_data;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch responder: serves CPU fetches from a req/ack instruction
// memory, with a one-entry PC+4 prefetch buffer for straight-line code.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter bit          PREFETCH_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [31:0]       pc,
    input  logic              flush,
    output logic              cpu_ready,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    output logic              fetch_fault,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata
);

    fetch_state_t      r_state;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [INST_W-1:0] r_inst;
    logic [31:0]       r_inst_pc;
    logic              r_inst_valid;
    logic              r_fault;
    logic              r_pend;
    logic              r_branch;
    logic              r_discard;
    logic [31:0]       r_req_pc;
    logic [ADDR_W-1:0] r_req_word;

    logic [ADDR_W-1:0] w_word;
    logic              w_misalign;
    logic              w_ready;
    logic              w_accept;
    logic              w_demand_acc;
    logic              w_hit_c;
    logic              w_buf_hit;
    logic              w_pref_match;
    logic              w_buf_load;
    logic [INST_W-1:0] w_buf_data;

    assign w_word       = pc[ADDR_W+1:2];
    assign w_misalign   = |pc[1:0];
    assign w_ready      = !rst && ((r_state == IDLE) ||
                                   ((r_state == PREF) && !r_pend && !r_branch));
    assign w_accept     = cpu_req && w_ready;
    assign w_demand_acc = w_accept && !w_misalign;
    assign w_buf_hit    = w_demand_acc && (r_state == IDLE) && w_hit_c && !flush;
    // A request for the word already being prefetched rides on that transaction.
    assign w_pref_match = w_demand_acc && (r_state == PREF) && !r_discard && !flush &&
                          (w_word == r_mem_addr);
    assign w_buf_load   = (r_state == PREF) && mem_ack && !r_pend && !r_branch &&
                          !r_discard && !flush && !w_demand_acc;

    prefetch_buf #(
        .ADDR_W(ADDR_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_buf_load),
        .i_load_tag  (r_mem_addr),
        .i_load_data (mem_rdata),
        .i_consume   (w_buf_hit),
        .i_invalidate(flush),
        .i_lookup_tag(w_word),
        .o_hit_c     (w_hit_c),
        .o_data      (w_buf_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_pend       <= 1'b0;
            r_branch     <= 1'b0;
            r_discard    <= 1'b0;
            r_req_pc     <= '0;
            r_req_word   <= '0;
        end else begin
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
            if (w_accept && w_misalign) begin
                r_inst_valid <= 1'b1;
                r_fault      <= 1'b1;
                r_inst       <= NOP_INST;
                r_inst_pc    <= pc;
            end
            case (r_state)
                IDLE: begin
                    if (w_buf_hit) begin
                        r_inst_valid <= 1'b1;
                        r_inst       <= w_buf_data;
                        r_inst_pc    <= pc;
                        if (PREFETCH_EN) begin
                            r_state    <= PREF;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_word + ADDR_W'(1);
                        end
                    end else if (w_demand_acc) begin
                        r_state    <= DEMAND;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_word;
                        r_req_pc   <= pc;
                    end
                end
                DEMAND: begin
                    if (mem_ack) begin
                        r_inst_valid <= 1'b1;
                        r_inst       <= mem_rdata;
                        r_inst_pc    <= r_req_pc;
                        if (PREFETCH_EN) begin
                            r_state    <= PREF;
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        end else begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                PREF: begin
                    if (mem_ack) begin
                        r_pend    <= 1'b0;
                        r_branch  <= 1'b0;
                        r_discard <= 1'b0;
                        if (r_pend || w_pref_match) begin
                            r_inst_valid <= 1'b1;
                            r_inst       <= mem_rdata;
                            r_inst_pc    <= r_pend ? r_req_pc : pc;
                            r_mem_addr   <= r_mem_addr + ADDR_W'(1);
                        end else if (r_branch || w_demand_acc) begin
                            // Prefetched word is dropped; fetch the branch target.
                            r_state    <= DEMAND;
                            r_mem_addr <= r_branch ? r_req_word : w_word;
                            if (!r_branch) begin
                                r_req_pc <= pc;
                            end
                        end else begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end else begin
                        r_discard <= r_discard || flush;
                        if (w_pref_match) begin
                            r_pend   <= 1'b1;
                            r_req_pc <= pc;
                        end else if (w_demand_acc) begin
                            r_branch   <= 1'b1;
                            r_req_pc   <= pc;
                            r_req_word <= w_word;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ready   = w_ready;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
    assign inst_valid  = r_inst_valid;
    assign fetch_fault = r_fault;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;

endmodule
